// File: rtl/otter_ctrl_pkg.sv
// rtl/otter_ctrl_pkg.sv - shared OTTER control encodings: immediate formats, opcodes, mux selects, FSM states
package otter_ctrl_pkg;

    // Immediate-format select, shared with the immediate generator
    typedef enum logic [2:0] {
        I_IMMED = 3'd0,
        S_IMMED = 3'd1,
        B_IMMED = 3'd2,
        U_IMMED = 3'd3,
        J_IMMED = 3'd4
    } immed_src_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMMED  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] PC_SRC_ALU_RESULT = 2'd0;
    localparam logic [1:0] PC_SRC_ALU_OUT    = 2'd1;
    localparam logic [1:0] PC_SRC_JALR       = 2'd2;

    localparam logic [1:0] RES_ALU_OUT    = 2'd0;
    localparam logic [1:0] RES_MEM        = 2'd1;
    localparam logic [1:0] RES_ALU_RESULT = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EX_R, ST_EX_I, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WR,
        ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR, ST_LUI, ST_AUIPC, ST_ILLEGAL
    } state_t;

    // Registered control word; the mem_rdy/br_taken-qualified strobes are added at the top
    typedef struct packed {
        logic [2:0] immed_src;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - opcode to execute-state and immediate-format lookup
module mc_opcode_decode
    import otter_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output state_t     next_state,
    output logic [2:0] immed_src
);

    // Dispatch table used on the DECODE exit
    always_comb begin
        next_state = ST_ILLEGAL;
        immed_src  = I_IMMED;
        case (opcode)
            OPC_OP:     next_state = ST_EX_R;
            OPC_OP_IMM: next_state = ST_EX_I;
            OPC_LOAD:   next_state = ST_MEM_ADDR;
            OPC_STORE: begin
                next_state = ST_MEM_ADDR;
                immed_src  = S_IMMED;
            end
            OPC_BRANCH: begin
                next_state = ST_BRANCH;
                immed_src  = B_IMMED;
            end
            OPC_JAL: begin
                next_state = ST_JAL;
                immed_src  = J_IMMED;
            end
            OPC_JALR:   next_state = ST_JALR;
            OPC_LUI: begin
                next_state = ST_LUI;
                immed_src  = U_IMMED;
            end
            OPC_AUIPC: begin
                next_state = ST_AUIPC;
                immed_src  = U_IMMED;
            end
            default:    next_state = ST_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - OTTER multicycle control FSM; MC_FSM_ILLEGAL_TRAP_EN makes illegal opcodes trap until reset
module mc_control_fsm
    import otter_ctrl_pkg::*;
#(
    parameter bit RESET_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inst,
    input  logic        mem_rdy,
    input  logic        br_taken,
    output logic [2:0]  immed_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  result_src,
    output logic        illegal
);

    state_t     state;
    state_t     state_nx;
    state_t     dec_state;
    logic [2:0] dec_immed;
    logic       is_store;
    ctrl_t      ctrl;
    ctrl_t      ctrl_nx;
    logic       handshake;
    logic       inst_unused;

    // Only the opcode steers sequencing; the rest of the word belongs to the datapath
    assign inst_unused = ^inst[31:7];

    mc_opcode_decode u_opcode_decode (
        .opcode     (inst[6:0]),
        .next_state (dec_state),
        .immed_src  (dec_immed)
    );

    // A request completes only while it is actually being driven
    assign handshake = ctrl.mem_req & mem_rdy;

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (start) state_nx = ST_FETCH;
            ST_FETCH:    if (handshake) state_nx = ST_DECODE;
            ST_DECODE:   state_nx = dec_state;
            ST_EX_R:     state_nx = ST_WB_ALU;
            ST_EX_I:     state_nx = ST_WB_ALU;
            ST_MEM_ADDR: state_nx = is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (handshake) state_nx = ST_WB_MEM;
            ST_MEM_WR:   if (handshake) state_nx = ST_FETCH;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
            ST_ILLEGAL:  state_nx = ST_ILLEGAL;
`else
            ST_ILLEGAL:  state_nx = ST_FETCH;
`endif
            default:     state_nx = ST_FETCH;
        endcase
    end

    // Moore control word for the state being entered, registered alongside it
    always_comb begin
        ctrl_nx = '0;
        case (state_nx)
            ST_FETCH: begin
                ctrl_nx.mem_req   = 1'b1;
                ctrl_nx.alu_src_a = SRC_A_PC;
                ctrl_nx.alu_src_b = SRC_B_FOUR;
                ctrl_nx.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                ctrl_nx.alu_src_a = SRC_A_OLD_PC;
                ctrl_nx.alu_src_b = SRC_B_IMMED;
                ctrl_nx.immed_src = B_IMMED;
            end
            ST_EX_R: begin
                ctrl_nx.alu_src_a = SRC_A_RS1;
                ctrl_nx.alu_src_b = SRC_B_RS2;
                ctrl_nx.alu_op    = ALU_FUNCT;
            end
            ST_EX_I: begin
                ctrl_nx.immed_src = I_IMMED;
                ctrl_nx.alu_src_a = SRC_A_RS1;
                ctrl_nx.alu_src_b = SRC_B_IMMED;
                ctrl_nx.alu_op    = ALU_FUNCT;
            end
            ST_MEM_ADDR: begin
                // Entered only from DECODE, so the lookup still sees this instruction
                ctrl_nx.immed_src = dec_immed;
                ctrl_nx.alu_src_a = SRC_A_RS1;
                ctrl_nx.alu_src_b = SRC_B_IMMED;
                ctrl_nx.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: ctrl_nx.mem_req = 1'b1;
            ST_MEM_WR: begin
                ctrl_nx.mem_req = 1'b1;
                ctrl_nx.mem_we  = 1'b1;
            end
            ST_WB_ALU: begin
                ctrl_nx.reg_we     = 1'b1;
                ctrl_nx.result_src = RES_ALU_OUT;
            end
            ST_WB_MEM: begin
                ctrl_nx.reg_we     = 1'b1;
                ctrl_nx.result_src = RES_MEM;
            end
            ST_BRANCH: begin
                ctrl_nx.alu_op    = ALU_SUB;
                ctrl_nx.alu_src_a = SRC_A_RS1;
                ctrl_nx.alu_src_b = SRC_B_RS2;
                ctrl_nx.pc_src    = PC_SRC_ALU_OUT;
            end
            ST_JAL: begin
                ctrl_nx.immed_src  = J_IMMED;
                ctrl_nx.alu_src_a  = SRC_A_OLD_PC;
                ctrl_nx.alu_src_b  = SRC_B_IMMED;
                ctrl_nx.pc_we      = 1'b1;
                ctrl_nx.pc_src     = PC_SRC_ALU_RESULT;
                ctrl_nx.reg_we     = 1'b1;
                ctrl_nx.result_src = RES_ALU_OUT;
            end
            ST_JALR: begin
                ctrl_nx.immed_src  = I_IMMED;
                ctrl_nx.alu_src_a  = SRC_A_RS1;
                ctrl_nx.alu_src_b  = SRC_B_IMMED;
                ctrl_nx.pc_we      = 1'b1;
                ctrl_nx.pc_src     = PC_SRC_JALR;
                ctrl_nx.reg_we     = 1'b1;
                ctrl_nx.result_src = RES_ALU_OUT;
            end
            ST_LUI: begin
                ctrl_nx.immed_src  = U_IMMED;
                ctrl_nx.alu_src_a  = SRC_A_ZERO;
                ctrl_nx.alu_src_b  = SRC_B_IMMED;
                ctrl_nx.reg_we     = 1'b1;
                ctrl_nx.result_src = RES_ALU_RESULT;
            end
            ST_AUIPC: begin
                ctrl_nx.immed_src  = U_IMMED;
                ctrl_nx.alu_src_a  = SRC_A_OLD_PC;
                ctrl_nx.alu_src_b  = SRC_B_IMMED;
                ctrl_nx.reg_we     = 1'b1;
                ctrl_nx.result_src = RES_ALU_RESULT;
            end
`ifdef MC_FSM_ILLEGAL_TRAP_EN
            ST_ILLEGAL: ctrl_nx.illegal = 1'b1;
`endif
            default: ctrl_nx = '0;
        endcase
    end

    // State, control word and the load/store flag latched on the DECODE exit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_FETCH ? ST_FETCH : ST_IDLE;
            ctrl     <= '0;
            is_store <= 1'b0;
        end else begin
            state <= state_nx;
            ctrl  <= ctrl_nx;
            if (state == ST_DECODE) begin
                is_store <= (inst[6:0] == OPC_STORE);
            end
        end
    end

    // Completion strobes: IR/PC load on the fetch handshake, PC load on a taken branch
    assign ir_we      = (state == ST_FETCH) & handshake;
    assign pc_we      = ctrl.pc_we | ir_we | ((state == ST_BRANCH) & br_taken);
    assign immed_src  = ctrl.immed_src;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign reg_we     = ctrl.reg_we;
    assign result_src = ctrl.result_src;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm against a per-instruction cycle model
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] inst;
    logic        mem_rdy;
    logic        br_taken;
    logic [2:0]  immed_src;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  result_src;
    logic        illegal;

    mc_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .inst       (inst),
        .mem_rdy    (mem_rdy),
        .br_taken   (br_taken),
        .immed_src  (immed_src),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .result_src (result_src),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observable control vector: imm, ir_we, pc_we, pc_src, a, b, op, req, we, reg_we, res, illegal
    typedef logic [18:0] vec_t;

    // rdy/brv: 0 or 1 = drive that value, 2 = drive random
    typedef struct {
        vec_t e;
        int   rdy;
        int   brv;
        bit   hold;
    } step_t;

    step_t q[$];

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5;
    localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

    function automatic vec_t mk(int imm, int irw, int pcw, int pcs, int a, int b, int op,
                                int req, int we, int rw, int res, int ill);
        vec_t v;
        v = {imm[2:0], irw[0], pcw[0], pcs[1:0], a[1:0], b[1:0], op[1:0],
             req[0], we[0], rw[0], res[1:0], ill[0]};
        return v;
    endfunction

    function automatic void push(vec_t e, int rdy, int brv, bit hold);
        step_t s;
        s.e = e; s.rdy = rdy; s.brv = brv; s.hold = hold;
        q.push_back(s);
    endfunction

    // Expected cycle sequence of one instruction, fetch wait fw, data-memory wait mw
    function automatic void build(int cls, int br, int fw, int mw);
        q.delete();
        for (int i = 0; i < fw; i++) push(mk(0,0,0,0, 0,2,0, 1,0,0,0,0), 0, 2, 1);
        push(mk(0,1,1,0, 0,2,0, 1,0,0,0,0), 1, 2, 1);
        push(mk(2,0,0,0, 1,1,0, 0,0,0,0,0), 2, 2, 1);
        case (cls)
            C_R: begin
                push(mk(0,0,0,0, 2,0,2, 0,0,0,0,0), 2, 2, 0);
                push(mk(0,0,0,0, 0,0,0, 0,0,1,0,0), 2, 2, 0);
            end
            C_I: begin
                push(mk(0,0,0,0, 2,1,2, 0,0,0,0,0), 2, 2, 0);
                push(mk(0,0,0,0, 0,0,0, 0,0,1,0,0), 2, 2, 0);
            end
            C_LD: begin
                push(mk(0,0,0,0, 2,1,0, 0,0,0,0,0), 2, 2, 0);
                for (int i = 0; i < mw; i++) push(mk(0,0,0,0, 0,0,0, 1,0,0,0,0), 0, 2, 0);
                push(mk(0,0,0,0, 0,0,0, 1,0,0,0,0), 1, 2, 0);
                push(mk(0,0,0,0, 0,0,0, 0,0,1,1,0), 2, 2, 0);
            end
            C_ST: begin
                push(mk(1,0,0,0, 2,1,0, 0,0,0,0,0), 2, 2, 0);
                for (int i = 0; i < mw; i++) push(mk(0,0,0,0, 0,0,0, 1,1,0,0,0), 0, 2, 0);
                push(mk(0,0,0,0, 0,0,0, 1,1,0,0,0), 1, 2, 0);
            end
            C_BR:    push(mk(0,0,br,1, 2,0,1, 0,0,0,0,0), 2, br, 0);
            C_JAL:   push(mk(4,0,1,0, 1,1,0, 0,0,1,0,0), 2, 2, 0);
            C_JALR:  push(mk(0,0,1,2, 2,1,0, 0,0,1,0,0), 2, 2, 0);
            C_LUI:   push(mk(3,0,0,0, 3,1,0, 0,0,1,2,0), 2, 2, 0);
            C_AUIPC: push(mk(3,0,0,0, 1,1,0, 0,0,1,2,0), 2, 2, 0);
            default: push(mk(0,0,0,0, 0,0,0, 0,0,0,0,0), 2, 2, 0);
        endcase
    endfunction

    function automatic logic [31:0] gen_inst(int cls);
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom();
        case (cls)
            C_R:     opc = 7'b0110011;
            C_I:     opc = 7'b0010011;
            C_LD:    opc = 7'b0000011;
            C_ST:    opc = 7'b0100011;
            C_BR:    opc = 7'b1100011;
            C_JAL:   opc = 7'b1101111;
            C_JALR:  opc = 7'b1100111;
            C_LUI:   opc = 7'b0110111;
            C_AUIPC: opc = 7'b0010111;
            default: begin
                opc = r[6:0];
                while (opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111})
                    opc = 7'($urandom());
            end
        endcase
        return {r[31:7], opc};
    endfunction

    // Play up to n queued steps (n < 0: all), one per clock, checking after inputs settle
    task automatic run_seq(string name, logic [31:0] word, int n);
        vec_t got;
        int   lim;
        lim = (n < 0 || n > q.size()) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            inst     = q[i].hold ? word : $urandom();
            mem_rdy  = (q[i].rdy == 2) ? 1'($urandom()) : 1'(q[i].rdy);
            br_taken = (q[i].brv == 2) ? 1'($urandom()) : 1'(q[i].brv);
            start    = 1'($urandom());
            #1;
            got = {immed_src, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
                   mem_req, mem_we, reg_we, result_src, illegal};
            checks++;
            if (got !== q[i].e) begin
                errors++;
                $display("FAIL %s step %0d: got %h expected %h", name, i, got, q[i].e);
            end
            @(negedge clk);
        end
    endtask

    // One reset cycle, then the post-reset cycle must show all-zero outputs even with mem_rdy high
    task automatic do_reset(string name);
        vec_t got;
        rst     = 1'b1;
        mem_rdy = 1'($urandom());
        @(negedge clk);
        rst     = 1'b0;
        mem_rdy = 1'b1;
        #1;
        got = {immed_src, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
               mem_req, mem_we, reg_we, result_src, illegal};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected 0", name, got);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset("reset_state");
    endtask

    task automatic test_addi();
        build(C_I, 0, 0, 0);
        run_seq("addi", 32'h00500093, -1);
    endtask

    task automatic test_sw_wait();
        build(C_ST, 0, 0, 3);
        run_seq("sw_wait3", 32'h00112023, -1);
    endtask

    task automatic test_beq();
        build(C_BR, 0, 0, 0);
        run_seq("beq_not_taken", 32'h00208463, -1);
        build(C_BR, 1, 1, 0);
        run_seq("beq_taken", 32'h00208463, -1);
    endtask

    task automatic test_jal();
        build(C_JAL, 0, 0, 0);
        run_seq("jal", 32'h008000EF, -1);
    endtask

    task automatic test_reset_mid_wait();
        build(C_LD, 0, 1, 6);
        run_seq("load_pre_reset", 32'h0000A083, 6);
        do_reset("reset_mid_mem_rd");
        build(C_I, 0, 0, 0);
        run_seq("addi_after_reset", 32'h00500093, -1);
    endtask

    task automatic test_illegal();
`ifdef MC_FSM_ILLEGAL_TRAP_EN
        build(C_ILL, 0, 0, 0);
        void'(q.pop_back());
        for (int i = 0; i < 12; i++) push(mk(0,0,0,0, 0,0,0, 0,0,0,0,1), 2, 2, 0);
        run_seq("illegal_trap", 32'hFFFFFFFF, -1);
        do_reset("reset_after_trap");
`else
        build(C_ILL, 0, 0, 0);
        run_seq("illegal_nop", 32'hFFFFFFFF, -1);
        build(C_I, 0, 0, 0);
        run_seq("fetch_after_illegal", 32'h00500093, -1);
`endif
    endtask

    task automatic test_back_to_back();
        int cls;
        int ncls;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
        ncls = 9;
`else
        ncls = 10;
`endif
        for (int n = 0; n < 300; n++) begin
            cls = $urandom_range(ncls - 1, 0);
            build(cls, $urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0));
            run_seq($sformatf("random_%0d_cls%0d", n, cls), gen_inst(cls), -1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        inst     = '0;
        mem_rdy  = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_sw_wait();
        test_beq();
        test_jal();
        test_reset_mid_wait();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
